// File: rtl/adder_subtractor_gate_level_pkg.sv
// Shared constants for the gate-level adder/subtractor.
// Holds the default operand width and the mode encodings.
package adder_subtractor_pkg;

    localparam int   DEF_N    = 8;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/adder_subtractor_gate_level_if.sv
// Operand/result bundle for adder_subtractor_gate_level.
// master: drives A, B, mode, in_valid; slave: returns S, Cout, out_valid (+V).
// Optional V (signed overflow) exists only with ADDSUB_OVERFLOW_EN defined.
interface adder_subtractor_gate_level_if
    import adder_subtractor_pkg::*;
#(
    parameter int N = DEF_N
);

    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         mode;
    logic         in_valid;
    logic [N-1:0] S;
    logic         Cout;
    logic         out_valid;
`ifdef ADDSUB_OVERFLOW_EN
    logic         V;

    modport master (
        output A, B, mode, in_valid,
        input  S, Cout, out_valid, V
    );

    modport slave (
        input  A, B, mode, in_valid,
        output S, Cout, out_valid, V
    );
`else
    modport master (
        output A, B, mode, in_valid,
        input  S, Cout, out_valid
    );

    modport slave (
        input  A, B, mode, in_valid,
        output S, Cout, out_valid
    );
`endif

endinterface

// File: rtl/adder_subtractor_gate_level_full_adder.sv
// One-bit full adder built only from XOR/AND/OR gate primitives.
// Ports: a, b, ci in; s (sum), co (carry out) out.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;
    logic g;
    logic t;

    xor u_p  (p, a, b);
    xor u_s  (s, p, ci);
    and u_g  (g, a, b);
    and u_t  (t, p, ci);
    or  u_co (co, g, t);

endmodule

// File: rtl/adder_subtractor_gate_level.sv
// Registered N-bit ripple-carry adder/subtractor, one op per cycle.
// Ports: clk, rst_n (async active-low), bus (slave modport: A, B, mode,
// in_valid -> S, Cout, out_valid, and V when ADDSUB_OVERFLOW_EN is defined).
module adder_subtractor_gate_level
    import adder_subtractor_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic                          clk,
    input  logic                          rst_n,
    adder_subtractor_gate_level_if.slave  bus
);

    logic [N-1:0] bx;
    logic [N-1:0] sum;
    logic [N:0]   c;
    logic         run;
    logic         accept;
    logic [N-1:0] s_q;
    logic         cout_q;
    logic         ov_q;

    // Subtract is A + ~B + 1: invert B per bit and feed mode as carry-in.
    assign c[0] = bus.mode;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            xor u_inv (bx[i], bus.B[i], bus.mode);

            full_adder u_fa (
                .a  (bus.A[i]),
                .b  (bx[i]),
                .ci (c[i]),
                .s  (sum[i]),
                .co (c[i+1])
            );
        end
    endgenerate

    // Set by the first edge after reset release, so the second edge
    // is the first one that can accept an operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    assign accept = bus.in_valid & run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            ov_q <= accept;
            if (accept) begin
                s_q    <= sum;
                cout_q <= c[N];
            end
        end
    end

    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.out_valid = ov_q;

`ifdef ADDSUB_OVERFLOW_EN
    logic v_d;
    logic v_q;

    // Signed overflow: carry into MSB differs from carry out of MSB.
    xor u_v (v_d, c[N], c[N-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
        end else if (accept) begin
            v_q <= v_d;
        end
    end

    assign bus.V = v_q;
`endif

endmodule

// File: tb/tb_adder_subtractor_gate_level.sv
// Self-checking bench for adder_subtractor_gate_level.
// Arithmetic reference model plus literal directed vectors.
`timescale 1ns/1ps
module tb_adder_subtractor_gate_level;
    import adder_subtractor_pkg::*;

    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    adder_subtractor_gate_level_if #(.N(N)) bus ();

    adder_subtractor_gate_level #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic res_t model_op(input int a, input int b, input logic m);
        res_t r;
        int   as;
        int   bs;
        int   full;
        int   sv;
        as = (a >= 128) ? a - 256 : a;
        bs = (b >= 128) ? b - 256 : b;
        if (m == MODE_SUB) begin
            full = a - b;
            r.c  = (a >= b);
            sv   = as - bs;
        end else begin
            full = a + b;
            r.c  = (full >= 256);
            sv   = as + bs;
        end
        r.s = full[N-1:0];
        r.v = (sv > 127) || (sv < -128);
        return r;
    endfunction

    logic [N-1:0] m_s  = '0;
    logic         m_c  = 1'b0;
    logic         m_v  = 1'b0;
    logic         m_ov = 1'b0;
    int           rel_edges = 0;

    // Model: operations are honoured from the second edge after release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s       <= '0;
            m_c       <= 1'b0;
            m_v       <= 1'b0;
            m_ov      <= 1'b0;
            rel_edges <= 0;
        end else begin
            m_ov <= 1'b0;
            if (rel_edges >= 1 && bus.in_valid) begin
                res_t r;
                r = model_op(int'(bus.A), int'(bus.B), bus.mode);
                m_s  <= r.s;
                m_c  <= r.c;
                m_v  <= r.v;
                m_ov <= 1'b1;
            end
            if (rel_edges < 2) rel_edges <= rel_edges + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("S", 32'(bus.S), 32'(m_s));
        chk("Cout", 32'(bus.Cout), 32'(m_c));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
`ifdef ADDSUB_OVERFLOW_EN
        chk("V", 32'(bus.V), 32'(m_v));
`endif
    end

    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic m, input logic v);
        bus.A        = a;
        bus.B        = b;
        bus.mode     = m;
        bus.in_valid = v;
    endtask

    logic [N-1:0] va [7] = '{8'h01, 8'h7F, 8'hFF, 8'h89, 8'hFF, 8'h04, 8'hAA};
    logic [N-1:0] vb [7] = '{8'h02, 8'h01, 8'hFF, 8'h03, 8'h01, 8'h0A, 8'hAA};
    logic         vm [7] = '{MODE_ADD, MODE_ADD, MODE_ADD, MODE_SUB,
                             MODE_SUB, MODE_SUB, MODE_SUB};
    logic [N-1:0] es [7] = '{8'h03, 8'h80, 8'hFE, 8'h86, 8'hFE, 8'hFA, 8'h00};
    logic         ec [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         ev [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    function automatic logic [N-1:0] pick();
        logic [N-1:0] r;
        case ($urandom_range(7))
            0: r = 8'h00;
            1: r = 8'hFF;
            2: r = 8'h80;
            3: r = 8'h7F;
            default: r = N'($urandom);
        endcase
        return r;
    endfunction

    initial begin
        drive(8'h00, 8'h00, MODE_ADD, 1'b0);
        #1;
        chk("rst_S", 32'(bus.S), 32'h0);
        chk("rst_Cout", 32'(bus.Cout), 32'h0);
        chk("rst_ov", 32'(bus.out_valid), 32'h0);
        #22 rst_n = 1'b1;

        // Directed vectors back-to-back, then an idle gap.
        @(posedge clk);
        #2 drive(va[0], vb[0], vm[0], 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            chk("dir_S", 32'(bus.S), 32'(es[i]));
            chk("dir_Cout", 32'(bus.Cout), 32'(ec[i]));
            chk("dir_ov", 32'(bus.out_valid), 32'h1);
`ifdef ADDSUB_OVERFLOW_EN
            chk("dir_V", 32'(bus.V), 32'(ev[i]));
`endif
            #1;
            if (i < 6) drive(va[i+1], vb[i+1], vm[i+1], 1'b1);
            else       drive(8'h55, 8'h33, MODE_ADD, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("gap_S", 32'(bus.S), 32'h00);
            chk("gap_Cout", 32'(bus.Cout), 32'h1);
            chk("gap_ov", 32'(bus.out_valid), 32'h0);
            #1;
        end

        for (int n = 0; n < 1500; n++) begin
            @(posedge clk);
            #2;
            if (n == 700) begin
                // Mid-stream reset while an operation is offered.
                drive(8'h10, 8'h05, MODE_SUB, 1'b1);
                #2 rst_n = 1'b0;
                #1;
                chk("async_S", 32'(bus.S), 32'h0);
                chk("async_Cout", 32'(bus.Cout), 32'h0);
                chk("async_ov", 32'(bus.out_valid), 32'h0);
                @(posedge clk);
                #4 rst_n = 1'b1;
                @(posedge clk);
                #1;
                chk("rel_edge1_ov", 32'(bus.out_valid), 32'h0);
                chk("rel_edge1_S", 32'(bus.S), 32'h0);
                @(posedge clk);
                #1;
                chk("rel_edge2_ov", 32'(bus.out_valid), 32'h1);
                chk("rel_edge2_S", 32'(bus.S), 32'h0B);
                chk("rel_edge2_Cout", 32'(bus.Cout), 32'h1);
                #1;
            end
            drive(pick(), pick(), 1'($urandom), ($urandom_range(3) != 0));
        end

        @(posedge clk);
        #2 drive(8'h00, 8'h00, MODE_ADD, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_subtractor_gate_level.md
ADDER_SUBTRACTOR_GATE_LEVEL -- requirements
Module: adder_subtractor_gate_level

Interface
REQ-001 Parameter N, default 8, operand and result width in bits; SHALL be legal for N >= 2.
REQ-002 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-004 Port A, input, N, operand A (minuend for subtraction).
REQ-005 Port B, input, N, operand B (subtrahend for subtraction).
REQ-006 Port mode, input, 1, operation select: 0 = add, 1 = subtract.
REQ-007 Port in_valid, input, 1, qualifies A/B/mode in the current cycle.
REQ-008 Port S, output, N, registered result.
REQ-009 Port Cout, output, 1, registered carry out of the MSB stage.
REQ-010 Port out_valid, output, 1, registered; high for exactly one cycle per accepted operation.

Function
REQ-011 Datapath SHALL compute A + (B XOR {N{mode}}) + mode through an N-stage ripple-carry chain; carry-in of stage 0 SHALL be mode.
REQ-012 Add: S = (A + B) mod 2^N; Cout = bit N of the unsigned sum (e.g. 255+255 -> S=254, Cout=1).
REQ-013 Subtract: S = (A - B) mod 2^N in two's complement; Cout = 1 when A >= B unsigned (no borrow), 0 when A < B.
REQ-014 Cycle with in_valid=1 at a rising edge: S, Cout SHALL show that operation's result after that edge (latency 1); out_valid=1 for that cycle.
REQ-015 Cycle with in_valid=0: S and Cout SHALL hold their previous values; out_valid=0.
REQ-016 Back-to-back in_valid=1 cycles SHALL each produce a result; throughput one operation per cycle, no stall or back-pressure.
REQ-017 No flags other than Cout (and V, REQ-022) SHALL be produced; wrap-around SHALL be silent.

Reset
REQ-018 rst_n=0 SHALL immediately (asynchronously) force S=0, Cout=0, out_valid=0 (and V=0 when present).
REQ-019 Reset deassertion SHALL be synchronised so that the first operation is accepted on the second rising clk edge after rst_n rises.
REQ-020 Reset asserted while in_valid=1 SHALL discard that operation; no out_valid pulse follows.

Configuration
REQ-021 Macro ADDSUB_OVERFLOW_EN SHALL control the signed-overflow feature.
REQ-022 Defined: extra output V, 1 bit, registered with S; V = carry into MSB XOR carry out of MSB (signed two's-complement overflow). Undefined: no V port, no related logic.

Structure
REQ-023 Shared package adder_subtractor_pkg SHALL hold the default width constant (8) and mode encodings MODE_ADD=1'b0, MODE_SUB=1'b1.
REQ-024 One sub-module, full_adder, SHALL be built from XOR/AND/OR gate primitives and instantiated N times by a generate loop; operand inversion SHALL use per-bit XOR gates; no behavioural '+' or '-' operators in the datapath.

Verification
REQ-025 Add: A=0x01, B=0x02, mode=0 -> S=0x03, Cout=0, V=0.
REQ-026 Add: A=0x7F, B=0x01, mode=0 -> S=0x80, Cout=0, V=1; A=0xFF, B=0xFF, mode=0 -> S=0xFE, Cout=1, V=0.
REQ-027 Subtract: A=0x89, B=0x03, mode=1 -> S=0x86, Cout=1; A=0xFF, B=0x01, mode=1 -> S=0xFE, Cout=1.
REQ-028 Subtract with borrow: A=0x04, B=0x0A, mode=1 -> S=0xFA (-6), Cout=0; equal operands A=B=0xAA, mode=1 -> S=0x00, Cout=1.
REQ-029 Timing: the REQ-025..028 vectors applied back-to-back with in_valid=1 -> each result one cycle later with out_valid=1; an in_valid=0 gap holds S/Cout with out_valid=0.
REQ-030 Reset: assert rst_n=0 mid-stream -> S=0, Cout=0, out_valid=0 without a clock edge; after release, first result appears per REQ-019.
